program_counter: RTL and testbench
==================================

# program_counter

The program counter register for the processor front end. It holds the address of the instruction being fetched and updates on every rising clock edge. The next value is either the sequential address (`pc_4`, computed upstream) or a branch target (`pc_branch_target`), selected by `branch`. It sits between the fetch adder/branch-resolution logic and the instruction memory address port.

## Interface
- `WIDTH`, default 32: address width in bits.
- `RESET_PC`, default 32'h0000_0000: value loaded into `pc` on reset.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `stall`  input  1  hold request; when 1, `pc` keeps its value.
- `branch`  input  1  when 1, select `pc_branch_target` as the next PC.
- `pc_branch_target`  input  WIDTH  branch/jump target address.
- `pc_4`  input  WIDTH  sequential next address (current pc + 4), supplied externally.
- `pc`  output  WIDTH  current program counter, driven directly from a register.
- `pc_misaligned`  output  1  1 when `pc[1:0] != 2'b00`.

## Operation
- Next-PC selection: `next = branch ? pc_branch_target : pc_4`.
- Update priority on each rising edge:
  - reset (`rst`=0): `pc <= RESET_PC`;
  - else if `stall`=1: hold;
  - else: `pc <= next`.
- `branch` and `stall` both high: the stall wins. The branch is not latched; upstream logic must keep `branch` asserted until the stall clears.
- The block performs no internal arithmetic. `pc_4` is used verbatim, even if it is not pc+4; verification must not assume an increment.
- Full WIDTH-bit values pass through unmodified. No masking of low bits, no wrap logic (wrap is the upstream adder's concern).
- `pc_misaligned` is purely combinational from the `pc` register.
  - It has no effect on the update itself; it is reported to the exception logic.
  - After reset with the default `RESET_PC`, it is 0.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on `pc` immediately after edge N.
- `pc` is glitch-free; it changes only on a clock edge or on reset assertion.
- Reset assertion forces `pc = RESET_PC` immediately, with no clock required.
- Reset mid-operation discards any pending branch or stall.
- Reset release is synchronous to the design; the first update occurs on the first rising edge with `rst`=1.
- Inputs must be stable for setup/hold around the rising edge. No handshake exists.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN` (32);
  - `RESET_VECTOR` constant;
  - `addr_t` typedef (`logic [XLEN-1:0]`).
- Natural sub-module: `pc_next_mux`. It is a combinational 2:1 selector for branch vs. sequential; the stall-hold decision stays in the register stage.
- Target RTL with assertions (reset value, hold-under-stall, one-cycle latency) and optional debug trace: about 120–200 lines.

## Test plan
- Reset:
  - Stimulus: `rst`=0 with `pc_4`=32'hABCDEF01, `branch`=0, no clock edge.
  - Required: `pc`=32'h00000000 immediately and `pc_misaligned`=0.
- Sequential path:
  - Stimulus: release `rst`, `branch`=0, `pc_4`=32'hABCDEF01, one rising edge.
  - Required: `pc`=32'hABCDEF01 and `pc_misaligned`=1.
- Branch path:
  - Stimulus: `branch`=1, `pc_branch_target`=32'h87654321, one edge.
  - Required: `pc`=32'h87654321.
  - Then `pc_branch_target`=32'h12345678, next edge: `pc`=32'h12345678.
- Stall:
  - Stimulus: `pc`=32'h00000100, `stall`=1, `branch`=1, target 32'h00000200, three edges.
  - Required: `pc` stays 32'h00000100.
  - Drop `stall` with `branch` still 1, one edge: `pc`=32'h00000200.
- Async reset mid-run:
  - Stimulus: `pc`=32'h87654321, assert `rst`=0 between edges.
  - Required: `pc`=32'h00000000 before the next edge, and it holds while reset is low regardless of `branch`/`pc_4`.
- Wide values:
  - Stimulus: `pc_4`=32'hFFFFFFFC, one edge.
  - Required: `pc`=32'hFFFFFFFC.
  - Then `pc_4`=32'h00000000, one edge: `pc`=32'h00000000 (no internal wrap logic).

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared processor-wide definitions for the front end.
//   XLEN         - architectural address/data width in bits
//   RESET_VECTOR - address the core fetches from after reset
//   addr_t       - XLEN-bit address type
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_VECTOR = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/pc_next_mux.sv
// ---------------------------------------------------------------------------
// pc_next_mux
// Combinational 2:1 selector between the sequential fetch address and a
// branch/jump target. It does not handle stalls; holding the PC belongs to
// the register stage.
// Ports:
//   branch           in  1      1 selects pc_branch_target
//   pc_branch_target in  WIDTH  resolved branch/jump target
//   pc_4             in  WIDTH  sequential address from the fetch adder
//   next_pc          out WIDTH  selected next program counter
// ---------------------------------------------------------------------------
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             branch,
    input  logic [WIDTH-1:0] pc_branch_target,
    input  logic [WIDTH-1:0] pc_4,
    output logic [WIDTH-1:0] next_pc
);

    always_comb begin
        next_pc = pc_4;
        if (branch) begin
            next_pc = pc_branch_target;
        end
    end

endmodule : pc_next_mux

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Holds the address of the instruction being fetched. On each rising edge it
// loads either the sequential address or the branch target, unless a stall
// is requested, in which case it holds. Values pass through untouched: no
// increment, masking or wrap happens here.
// Ports:
//   clk              in  1      system clock, rising edge active
//   rst              in  1      asynchronous, active-low reset
//   stall            in  1      1 holds the current pc
//   branch           in  1      1 selects pc_branch_target as next pc
//   pc_branch_target in  WIDTH  branch/jump target
//   pc_4             in  WIDTH  sequential next address, used verbatim
//   pc               out WIDTH  current program counter (register output)
//   pc_misaligned    out 1      1 when pc[1:0] is not zero
// ---------------------------------------------------------------------------
module program_counter
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch,
    input  logic [WIDTH-1:0] pc_branch_target,
    input  logic [WIDTH-1:0] pc_4,
    output logic [WIDTH-1:0] pc,
    output logic             pc_misaligned
);

    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    pc_next_mux #(
        .WIDTH(WIDTH)
    ) u_pc_next_mux (
        .branch          (branch),
        .pc_branch_target(pc_branch_target),
        .pc_4            (pc_4),
        .next_pc         (next_pc)
    );

    // A stall overrides a pending branch; the branch is not remembered, so
    // upstream must keep it asserted until the stall clears.
    always_comb begin
        pc_d = next_pc;
        if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    // Reported to exception logic only; it never gates the update.
    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    // While reset is held the register must sit at the reset address.
    a_reset_value : assert property (@(posedge clk) !rst |-> (pc_q == RESET_PC));

    // A stalled cycle leaves the pc unchanged.
    a_hold_under_stall : assert property (
        @(posedge clk) disable iff (!rst) stall |=> (pc_q == $past(pc_q)));

    // An unstalled cycle makes the selected address visible after one edge.
    a_one_cycle_latency : assert property (
        @(posedge clk) disable iff (!rst) !stall |=> (pc_q == $past(next_pc)));

endmodule : program_counter

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
// Directed bench for program_counter. Stimulus pushes hand-computed expected
// pc / pc_misaligned values into a scoreboard queue; a separate monitor pops
// and compares them on the falling edge after the update, or immediately
// for asynchronous reset checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_program_counter;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] pc_branch_target;
    logic [31:0] pc_4;
    logic [31:0] pc;
    logic        pc_misaligned;

    int totalChecks = 0;
    int badChecks   = 0;

    string       nameQ[$];
    logic [31:0] pcQ[$];
    logic        misQ[$];

    event asyncCheck;

    program_counter #(
        .WIDTH   (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch          (branch),
        .pc_branch_target(pc_branch_target),
        .pc_4            (pc_4),
        .pc              (pc),
        .pc_misaligned   (pc_misaligned)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and keep the tallies.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Record what the DUT should show at the next sampling point.
    task automatic pushExpect(input string name, input logic [31:0] expPc,
                              input logic expMis);
        nameQ.push_back(name);
        pcQ.push_back(expPc);
        misQ.push_back(expMis);
    endtask

    // Drive one cycle of inputs away from the rising edge and queue the pc
    // expected just after that edge.
    task automatic applyStimulus(input string name, input logic rstVal,
                                 input logic stallVal, input logic branchVal,
                                 input logic [31:0] target, input logic [31:0] seq,
                                 input logic [31:0] expPc, input logic expMis);
        @(negedge clk);
        #2;
        rst              = rstVal;
        stall            = stallVal;
        branch           = branchVal;
        pc_branch_target = target;
        pc_4             = seq;
        pushExpect(name, expPc, expMis);
    endtask

    // Pull reset low between edges and ask for an immediate check.
    task automatic assertResetMidCycle(input logic [31:0] target, input logic [31:0] seq);
        @(negedge clk);
        #2;
        rst              = 1'b0;
        branch           = 1'b1;
        pc_branch_target = target;
        pc_4             = seq;
        pushExpect("async_reset_mid", 32'h0000_0000, 1'b0);
        #1;
        ->asyncCheck;
    endtask

    // Monitor: pops one expectation per sampling point and compares it.
    initial begin
        string       nm;
        logic [31:0] ePc;
        logic        eMis;
        forever begin
            @(negedge clk or asyncCheck);
            if (pcQ.size() > 0) begin
                nm   = nameQ.pop_front();
                ePc  = pcQ.pop_front();
                eMis = misQ.pop_front();
                checkOutput({nm, "_pc"}, pc, ePc);
                checkOutput({nm, "_mis"}, {31'b0, pc_misaligned}, {31'b0, eMis});
            end
        end
    end

    // Hard stop in case something wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        rst              = 1'b0;
        stall            = 1'b0;
        branch           = 1'b0;
        pc_branch_target = 32'h0000_0000;
        pc_4             = 32'hABCD_EF01;
        #1;
        pushExpect("reset_no_clock", 32'h0000_0000, 1'b0);
        ->asyncCheck;

        // Sequential, branch, and non-increment pass-through.
        applyStimulus("seq_first",  1, 0, 0, 32'h0000_0000, 32'hABCD_EF01, 32'hABCD_EF01, 1);
        applyStimulus("branch_a",   1, 0, 1, 32'h8765_4321, 32'h1111_1110, 32'h8765_4321, 1);
        applyStimulus("branch_b",   1, 0, 1, 32'h1234_5678, 32'h1111_1110, 32'h1234_5678, 0);
        applyStimulus("seq_to_100", 1, 0, 0, 32'h5555_5554, 32'h0000_0100, 32'h0000_0100, 0);

        // Stall beats a pending branch for three edges, then the branch lands.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall_hold", 1, 1, 1, 32'h0000_0200, 32'hDEAD_BEE0, 32'h0000_0100, 0);
        end
        applyStimulus("stall_release", 1, 0, 1, 32'h0000_0200, 32'hDEAD_BEE0, 32'h0000_0200, 0);
        applyStimulus("stall_no_branch", 1, 1, 0, 32'h0000_0300, 32'h0000_0204, 32'h0000_0200, 0);
        applyStimulus("to_87654321", 1, 0, 1, 32'h8765_4321, 32'h0000_0204, 32'h8765_4321, 1);

        // Reset in the middle of a cycle, then held across edges with busy inputs.
        assertResetMidCycle(32'h1111_1110, 32'h2222_2224);
        applyStimulus("reset_hold_a", 0, 0, 1, 32'h3333_3330, 32'h4444_4444, 32'h0000_0000, 0);
        applyStimulus("reset_hold_b", 0, 0, 0, 32'h3333_3330, 32'h4444_4447, 32'h0000_0000, 0);

        // Full-width values and no wrap logic.
        applyStimulus("wide_top",  1, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
        applyStimulus("wide_zero", 1, 0, 0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 0);
        applyStimulus("odd_seq",   1, 0, 0, 32'h0000_0000, 32'h0000_0003, 32'h0000_0003, 1);
        applyStimulus("half_align",1, 0, 1, 32'hFFFF_FFFE, 32'h0000_0008, 32'hFFFF_FFFE, 1);

        // Let the monitor drain, but only for a bounded number of cycles.
        for (int i = 0; i < 5; i++) begin
            if (pcQ.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (pcQ.size() != 0) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL drain: got %0d pending, required 0", pcQ.size());
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule : tb_program_counter
